// File: rtl/act_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : act_stream_packer
// Description : Packs PACK activation samples into one wide word and buffers
//               words in a first-word-fall-through FIFO with overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module act_stream_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK       = 4,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          valid_in,
    input  logic                          last_in,
    input  logic                          clr_ovf,
    output logic [DATA_WIDTH*PACK-1:0]    out_data,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(DEPTH):0]        level
);

    localparam int c_IDX_W  = $clog2(PACK);
    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_WORD_W = DATA_WIDTH * PACK;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(PACK - 1);

    logic [c_IDX_W-1:0]  r_idx;
    logic [c_WORD_W-1:0] r_pack;
    logic [c_WORD_W-1:0] w_word;
    logic                w_done;

    logic [c_ADDR_W:0]   r_wptr;
    logic [c_ADDR_W:0]   r_rptr;
    logic [c_WORD_W-1:0] r_mem      [DEPTH];
    logic                r_last_mem [DEPTH];
    logic                r_overflow;

    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // ------------------------------------------------------------------
    // Packing: merge the incoming sample into its lane of the pack word
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < PACK; k++) begin : g_lane
            assign w_word[k*DATA_WIDTH +: DATA_WIDTH] =
                (valid_in && (r_idx == c_IDX_W'(k))) ? data_in
                                                     : r_pack[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign w_done = valid_in && ((r_idx == c_LAST_IDX) || last_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_pack <= '0;
        end else if (valid_in) begin
            if (w_done) begin
                // Cleared register guarantees zero upper lanes on a partial word
                r_idx  <= '0;
                r_pack <= '0;
            end else begin
                r_idx  <= r_idx + c_IDX_W'(1);
                r_pack <= w_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_ADDR_W] != r_rptr[c_ADDR_W]) &&
                     (r_wptr[c_ADDR_W-1:0] == r_rptr[c_ADDR_W-1:0]);
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle
    assign w_push  = w_done && (!w_full || w_pop);
    assign w_drop  = w_done && !w_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + (c_ADDR_W+1)'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + (c_ADDR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[c_ADDR_W-1:0]]      <= w_word;
            r_last_mem[r_wptr[c_ADDR_W-1:0]] <= last_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: head entry shown directly, forced to zero while empty
    // ------------------------------------------------------------------
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0   : r_mem[r_rptr[c_ADDR_W-1:0]];
    assign out_last  = w_empty ? 1'b0 : r_last_mem[r_rptr[c_ADDR_W-1:0]];
    assign overflow  = r_overflow;
    assign level     = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: tb/tb_act_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_act_stream_packer
// Description : Directed self-checking bench for act_stream_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_act_stream_packer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        last_in;
    logic        clr_ovf;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        overflow;
    logic [3:0]  level;

    int errors = 0;
    int checks = 0;

    act_stream_packer #(
        .DATA_WIDTH (8),
        .PACK       (4),
        .DEPTH      (8)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .clr_ovf   (clr_ovf),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one sample for one cycle; returns 1 time unit after the capturing edge
    task automatic sample(input logic [7:0] d, input logic l);
        data_in  = d;
        valid_in = 1'b1;
        last_in  = l;
        tick();
        data_in  = 8'h00;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    function automatic logic [7:0] sb(input int i, input int k);
        return 8'((i * 16) + k);
    endfunction

    function automatic logic [31:0] word(input int i);
        return {sb(i, 3), sb(i, 2), sb(i, 1), sb(i, 0)};
    endfunction

    task automatic word_in(input int i);
        for (int k = 0; k < 4; k++) begin
            sample(sb(i, k), 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        data_in   = 8'h00;
        valid_in  = 1'b0;
        last_in   = 1'b0;
        clr_ovf   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_level",     64'(level),     64'd0);
        check("reset_overflow",  64'(overflow),  64'd0);
        check("reset_out_data",  64'(out_data),  64'd0);
        check("reset_out_last",  64'(out_last),  64'd0);
        rst_n = 1'b1;
        tick();

        // Basic pack
        out_ready = 1'b1;
        sample(8'h01, 1'b0);
        sample(8'h02, 1'b0);
        sample(8'h03, 1'b0);
        check("basic_not_yet_valid", 64'(out_valid), 64'd0);
        sample(8'h04, 1'b0);
        check("basic_valid",    64'(out_valid), 64'd1);
        check("basic_data",     64'(out_data),  64'h04030201);
        check("basic_last",     64'(out_last),  64'd0);
        check("basic_level",    64'(level),     64'd1);
        tick();
        check("basic_one_cycle", 64'(out_valid), 64'd0);

        // Partial flush on last_in, then next sample back at lane 0
        sample(8'h7F, 1'b0);
        sample(8'h80, 1'b1);
        check("partial_valid", 64'(out_valid), 64'd1);
        check("partial_data",  64'(out_data),  64'h0000807F);
        check("partial_last",  64'(out_last),  64'd1);
        last_in = 1'b1;      // last_in without valid_in is ignored
        tick();
        last_in = 1'b0;
        check("partial_popped", 64'(out_valid), 64'd0);
        sample(8'h11, 1'b0);
        sample(8'h22, 1'b0);
        sample(8'h33, 1'b0);
        sample(8'h44, 1'b0);
        check("lane0_data", 64'(out_data), 64'h44332211);
        check("lane0_last", 64'(out_last), 64'd0);
        tick();

        // Backpressure fill and drop
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            word_in(i);
        end
        check("fill_level",    64'(level),    64'd8);
        check("fill_overflow", 64'(overflow), 64'd0);
        check("fill_head",     64'(out_data), 64'(word(0)));
        word_in(8);
        check("drop_level",    64'(level),    64'd8);
        check("drop_overflow", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_valid_%0d", i), 64'(out_valid), 64'd1);
            check($sformatf("drain_data_%0d", i),  64'(out_data),  64'(word(i)));
            tick();
        end
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_level", 64'(level),     64'd0);
        check("drain_overflow_sticky", 64'(overflow), 64'd1);

        // Sticky clear
        out_ready = 1'b0;
        clr_ovf   = 1'b1;
        tick();
        clr_ovf   = 1'b0;
        check("clear_overflow", 64'(overflow), 64'd0);

        // Full with simultaneous pop
        for (int i = 0; i < 8; i++) begin
            word_in(i);
        end
        check("refill_level", 64'(level), 64'd8);
        sample(sb(9, 0), 1'b0);
        sample(sb(9, 1), 1'b0);
        sample(sb(9, 2), 1'b0);
        out_ready = 1'b1;
        sample(sb(9, 3), 1'b0);
        out_ready = 1'b0;
        check("fullpop_level",    64'(level),    64'd8);
        check("fullpop_overflow", 64'(overflow), 64'd0);
        check("fullpop_head",     64'(out_data), 64'(word(1)));

        // Drop sets overflow; clr_ovf coinciding with a drop loses
        word_in(10);
        check("drop2_overflow", 64'(overflow), 64'd1);
        sample(sb(11, 0), 1'b0);
        sample(sb(11, 1), 1'b0);
        sample(sb(11, 2), 1'b0);
        clr_ovf = 1'b1;
        sample(sb(11, 3), 1'b0);
        clr_ovf = 1'b0;
        check("clr_vs_drop_overflow", 64'(overflow), 64'd1);
        check("clr_vs_drop_level",    64'(level),    64'd8);

        // Drain to level 3: remaining words 6, 7, 9
        out_ready = 1'b1;
        repeat (5) tick();
        out_ready = 1'b0;
        check("partial_drain_level", 64'(level),    64'd3);
        check("partial_drain_head",  64'(out_data), 64'(word(6)));

        // Asynchronous reset mid-word
        sample(8'hAA, 1'b0);
        sample(8'hBB, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_level",     64'(level),     64'd0);
        check("async_overflow",  64'(overflow),  64'd0);
        check("async_out_data",  64'(out_data),  64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        sample(8'hC1, 1'b0);
        sample(8'hC2, 1'b0);
        sample(8'hC3, 1'b0);
        sample(8'hC4, 1'b0);
        check("post_reset_data",  64'(out_data),  64'hC4C3C2C1);
        check("post_reset_level", 64'(level),     64'd1);
        check("post_reset_valid", 64'(out_valid), 64'd1);
        tick();
        check("post_reset_empty", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/act_stream_packer.md
Name: act_stream_packer

Overview:
- Receive side of the activation-unit output stream. It consumes the valid-only, no-backpressure sample stream (`data_in`/`valid_in`) produced by the hswish/hsigmoid/relu/relu6 stages.
- Packs PACK consecutive samples into one wide word and buffers words in a FIFO. Presents them on a valid/ready interface to the feature-map writer.
- Detects and flags overflow, because the upstream activation stage cannot be stalled.

Parameters:
- DATA_WIDTH, 8, width of one signed activation sample.
- PACK, 4, samples per output word (>=2).
- DEPTH, 8, FIFO depth in words (power of two, >=2).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  signed sample from activation stage.
- valid_in  input  1  sample strobe; one sample per cycle when high.
- last_in  input  1  qualifies valid_in; marks final sample of a tile.
- clr_ovf  input  1  synchronous clear of sticky overflow.
- out_data  output  DATA_WIDTH*PACK  packed word.
- out_last  output  1  word contains final sample of a tile.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts word.
- overflow  output  1  sticky: a completed word was dropped.
- level  output  $clog2(DEPTH)+1  FIFO occupancy in words.

Behaviour:
- Reset (async assert, sync release): pack index 0, pack register 0, FIFO empty; out_data 0, out_last 0, out_valid 0, overflow 0, level 0.
- Packing:
  - Sample k of a word (k = 0..PACK-1) lands in bits [k*DATA_WIDTH +: DATA_WIDTH]; sample 0 is the LSBs.
  - On valid_in, the sample is written at the current index and the index increments.
  - A word completes when the index reaches PACK-1, or when last_in=1 is seen with valid_in.
  - On completion the index returns to 0 and the pack register clears to 0.
- Partial words: on last_in, unfilled upper lanes are zero.
- Tagging: the completed word carries last = last_in.
- last_in without valid_in is ignored.
- Push:
  - A completed word is written into the FIFO on the same edge that captures its final sample.
  - The push is allowed if level < DEPTH, or if a pop occurs in the same cycle (level == DEPTH and out_valid & out_ready).
  - Otherwise the word is dropped, overflow is set, and level is unchanged.
- Pop: out_valid & out_ready advances the read pointer.
- Output presentation:
  - out_data/out_last show the head entry combinationally from FIFO storage (first-word fall-through).
  - out_data/out_last hold stable while out_valid=1 and out_ready=0.
- Latency: a word whose final sample arrives in cycle N has out_valid=1 in cycle N+1 if the FIFO was empty. There is no bubble for back-to-back words.
- Pointers:
  - Read and write pointers are $clog2(DEPTH)+1 bits with wrap bit.
  - full = MSBs differ and lower bits equal; empty = pointers equal.
  - level = wptr - rptr.
- Simultaneous push and pop: level unchanged, and both pointers advance.
  - When empty, a same-cycle push does not pop; out_valid rises next cycle.
- Overflow flag:
  - Remains set until clr_ovf=1.
  - If clr_ovf coincides with a new drop, set wins.
  - Packing state is unaffected by a drop; the next sample starts a new word at lane 0.
- Reset mid-operation: a partial pack and all FIFO contents are discarded, and outputs return to reset values asynchronously.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Basic pack: PACK=4, DW=8, drive samples 0x01,0x02,0x03,0x04 on consecutive cycles, out_ready=1 → one word 0x04030201 with out_valid for exactly 1 cycle, starting the cycle after the 4th sample; out_last=0.
- Partial flush: samples 0x7F then 0x80 with last_in on the second → word 0x0000807F, out_last=1. The next sample 0x11 lands in lane 0.
- Backpressure fill: out_ready=0, push 8 full words → level=8, overflow=0. A 9th word → dropped, overflow=1, level stays 8. Then out_ready=1 drains words 1..8 in order with correct contents.
- Full with simultaneous pop: level=8, 9th word completes in the same cycle as a pop → word accepted, level stays 8, overflow stays 0.
- Sticky clear: overflow=1, pulse clr_ovf → overflow=0 next cycle. clr_ovf coinciding with a drop → overflow remains 1.
- Async reset: assert rst_n=0 mid-word (2 of 4 samples captured) with level=3 → out_valid/level/overflow go to 0 without a clock edge. After release, a fresh 4-sample burst yields a word with those 4 samples only.
